background_index_arbiter: RTL and testbench

Shares the 64x32 single-port background-index on-chip RAM between two requesters.
- The display tile-fetch engine is the high-priority requester.
- The CPU Avalon-MM slave path is the low-priority requester, with anti-starvation.
- Sits between both requesters and the RAM's s1 port. It drives chipselect, write, debugaccess, byteenable and clken itself, and routes 1-cycle-latency read data back to the correct owner.

---
 rtl/bgidx_arb_pkg.sv | 16 +
 rtl/bgidx_starve_ctr.sv | 36 +++
 rtl/background_index_arbiter.sv | 142 ++++++++++++++
 tb/tb_background_index_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgidx_arb_pkg.sv
// Shared types and constants for the background-index RAM arbiter.
package bgidx_arb_pkg;

  localparam int unsigned BGIDX_ADDR_W = 6;
  localparam int unsigned BGIDX_DATA_W = 32;
  localparam int unsigned BGIDX_BE_W   = 4;

  localparam logic [BGIDX_BE_W-1:0] BGIDX_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/bgidx_starve_ctr.sv
// Saturating count of consecutive denied CPU cycles; at_limit lets the CPU win one cycle.
module bgidx_starve_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/background_index_arbiter.sv
// Arbitrates the background-index RAM between display fetch (high priority) and CPU Avalon slave.
// Optional grant/conflict statistics counters enabled by defining BGIDX_ARB_STATS_EN.
module background_index_arbiter
  import bgidx_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = BGIDX_ADDR_W,
  parameter int unsigned DATA_W       = BGIDX_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_W-1:0]     disp_addr,
  output logic                  disp_gnt,
  output logic [DATA_W-1:0]     disp_rdata,
  output logic                  disp_rvalid,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [BGIDX_BE_W-1:0] cpu_byteenable,
  input  logic [DATA_W-1:0]     cpu_writedata,
  output logic                  cpu_waitrequest,
  output logic [DATA_W-1:0]     cpu_readdata,
  output logic                  cpu_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_debugaccess,
  output logic [BGIDX_BE_W-1:0] mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
`ifdef BGIDX_ARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [15:0]           stat_disp_gnt,
  output logic [15:0]           stat_cpu_gnt,
  output logic [15:0]           stat_conflict
`endif
);

  logic   cpu_req;
  logic   cpu_gnt;
  logic   cpu_wr;
  logic   starve_hit;
  owner_t owner_q, owner_d;

  assign cpu_req = cpu_read | cpu_write;
  assign cpu_wr  = cpu_write;

  bgidx_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (cpu_req & ~cpu_gnt),
    .clr      (cpu_gnt | ~cpu_req),
    .at_limit (starve_hit)
  );

  always_comb begin
    cpu_gnt        = 1'b0;
    disp_gnt       = 1'b0;
    mem_address    = disp_addr;
    mem_write      = 1'b0;
    mem_debugaccess = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    owner_d        = OWN_NONE;
    if (!reset) begin
      cpu_gnt  = cpu_req & (~disp_req | starve_hit);
      disp_gnt = disp_req & ~cpu_gnt;
    end
    if (cpu_gnt) begin
      mem_address     = cpu_address;
      mem_byteenable  = cpu_byteenable;
      mem_writedata   = cpu_writedata;
      mem_write       = cpu_wr;
      mem_debugaccess = cpu_wr;
      owner_d         = cpu_wr ? OWN_NONE : OWN_CPU;
    end else if (disp_gnt) begin
      mem_byteenable = BGIDX_BE_ALL;
      owner_d        = OWN_DISP;
    end
  end

  assign mem_chipselect  = disp_gnt | cpu_gnt;
  assign mem_clken       = 1'b1;
  assign cpu_waitrequest = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Masking by reset kills a read granted the cycle before reset asserts.
  assign disp_rvalid       = ~reset & (owner_q == OWN_DISP);
  assign cpu_readdatavalid = ~reset & (owner_q == OWN_CPU);
  assign disp_rdata        = mem_readdata;
  assign cpu_readdata      = mem_readdata;

`ifdef BGIDX_ARB_STATS_EN
  logic [15:0] st_disp_q, st_disp_d;
  logic [15:0] st_cpu_q,  st_cpu_d;
  logic [15:0] st_conf_q, st_conf_d;

  always_comb begin
    st_disp_d = st_disp_q;
    st_cpu_d  = st_cpu_q;
    st_conf_d = st_conf_q;
    if (stat_clear) begin
      st_disp_d = '0;
      st_cpu_d  = '0;
      st_conf_d = '0;
    end else begin
      if (disp_gnt && (st_disp_q != '1)) st_disp_d = st_disp_q + 1'b1;
      if (cpu_gnt && (st_cpu_q != '1))   st_cpu_d  = st_cpu_q + 1'b1;
      if (disp_req && cpu_req && (st_conf_q != '1)) st_conf_d = st_conf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_disp_q <= '0;
      st_cpu_q  <= '0;
      st_conf_q <= '0;
    end else begin
      st_disp_q <= st_disp_d;
      st_cpu_q  <= st_cpu_d;
      st_conf_q <= st_conf_d;
    end
  end

  assign stat_disp_gnt = st_disp_q;
  assign stat_cpu_gnt  = st_cpu_q;
  assign stat_conflict = st_conf_q;
`endif

endmodule

// File: tb/tb_background_index_arbiter.sv
// Scoreboard bench for background_index_arbiter with a behavioural 64x32 RAM on s1.
module tb_background_index_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [5:0]  disp_addr;
  logic        disp_gnt;
  logic [31:0] disp_rdata;
  logic        disp_rvalid;
  logic [5:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_writedata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [5:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_debugaccess;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;
`ifdef BGIDX_ARB_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_disp_gnt;
  logic [15:0] stat_cpu_gnt;
  logic [15:0] stat_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] disp_q[$];
  logic [31:0] cpu_q[$];

  logic [31:0] ram [64];
  logic        ram_init;

  always #5 clk = ~clk;

  background_index_arbiter #(
    .STARVE_LIMIT (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .disp_req          (disp_req),
    .disp_addr         (disp_addr),
    .disp_gnt          (disp_gnt),
    .disp_rdata        (disp_rdata),
    .disp_rvalid       (disp_rvalid),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_byteenable    (cpu_byteenable),
    .cpu_writedata     (cpu_writedata),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_readdata      (cpu_readdata),
    .cpu_readdatavalid (cpu_readdatavalid),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_debugaccess   (mem_debugaccess),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata)
`ifdef BGIDX_ARB_STATS_EN
    ,
    .stat_clear        (stat_clear),
    .stat_disp_gnt     (stat_disp_gnt),
    .stat_cpu_gnt      (stat_cpu_gnt),
    .stat_conflict     (stat_conflict)
`endif
  );

  // Word i preloads to A5A5_00ii; word 63 preloads to all ones.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= (i == 63) ? 32'hFFFF_FFFF : (32'hA5A5_0000 | 32'(i));
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (disp_rvalid === 1'b1) begin
      if (disp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL disp_rvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else check("disp_rdata", disp_rdata, disp_q.pop_front());
    end
    if (cpu_readdatavalid === 1'b1) begin
      if (cpu_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL cpu_rdvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else check("cpu_readdata", cpu_readdata, cpu_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_byteenable = '0; cpu_writedata = '0;
`ifdef BGIDX_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    tick(); ram_init = 1'b0;
    disp_req = 1'b1; disp_addr = 6'd1; cpu_read = 1'b1; cpu_address = 6'd2;
    sample();
    check("rst_disp_gnt", 32'(disp_gnt), 0);
    check("rst_cpu_wait", 32'(cpu_waitrequest), 1);
    check("rst_chipselect", 32'(mem_chipselect), 0);
    check("rst_clken", 32'(mem_clken), 1);
    tick(); reset = 1'b0; disp_req = 1'b0; cpu_read = 1'b0;
    sample();
    check("post_rst_disp_rvalid", 32'(disp_rvalid), 0);
    check("post_rst_cpu_rdvalid", 32'(cpu_readdatavalid), 0);

    // Display read only
    tick(); disp_req = 1'b1; disp_addr = 6'h05;
    sample();
    check("d1_disp_gnt", 32'(disp_gnt), 1);
    check("d1_be", 32'(mem_byteenable), 32'hF);
    check("d1_mem_write", 32'(mem_write), 0);
    check("d1_addr", 32'(mem_address), 32'h05);
    disp_q.push_back(32'hA5A5_0005);
    tick(); disp_req = 1'b0;
    sample();
    check("d1_rvalid", 32'(disp_rvalid), 1);
    check("d1_cpu_rdvalid", 32'(cpu_readdatavalid), 0);

    // CPU write then read-after-write
    tick(); cpu_write = 1'b1; cpu_address = 6'h3F; cpu_byteenable = 4'b0011;
    cpu_writedata = 32'h1234_5678;
    sample();
    check("wr_wait", 32'(cpu_waitrequest), 0);
    check("wr_mem_write", 32'(mem_write), 1);
    check("wr_debugaccess", 32'(mem_debugaccess), 1);
    check("wr_be", 32'(mem_byteenable), 32'h3);
    check("wr_wdata", mem_writedata, 32'h1234_5678);
    tick(); cpu_write = 1'b0; cpu_read = 1'b1;
    sample();
    check("rd_wait", 32'(cpu_waitrequest), 0);
    check("rd_debugaccess", 32'(mem_debugaccess), 0);
    cpu_q.push_back(32'hFFFF_5678);
    tick(); cpu_read = 1'b0;
    sample();
    check("rd_rdvalid", 32'(cpu_readdatavalid), 1);

    // Contention: CPU waits 8 cycles, wins cycle 8, display back at 9
    tick(); disp_req = 1'b1; disp_addr = 6'd1; cpu_read = 1'b1; cpu_address = 6'd2;
    for (int i = 0; i < 8; i++) begin
      sample();
      check($sformatf("ct_wait_%0d", i), 32'(cpu_waitrequest), 1);
      check($sformatf("ct_dgnt_%0d", i), 32'(disp_gnt), 1);
      disp_q.push_back(32'hA5A5_0001);
      tick();
    end
    sample();
    check("ct_wait_8", 32'(cpu_waitrequest), 0);
    check("ct_dgnt_8", 32'(disp_gnt), 0);
    check("ct_addr_8", 32'(mem_address), 32'd2);
    cpu_q.push_back(32'hA5A5_0002);
    tick(); cpu_read = 1'b0;
    sample();
    check("ct_dgnt_9", 32'(disp_gnt), 1);
    disp_q.push_back(32'hA5A5_0001);
    tick(); disp_req = 1'b0;
    sample();

    // Simultaneous read and write behaves as a write
    tick(); cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 6'd10;
    cpu_byteenable = 4'hF; cpu_writedata = 32'hDEAD_BEEF;
    sample();
    check("rw_mem_write", 32'(mem_write), 1);
    check("rw_debugaccess", 32'(mem_debugaccess), 1);
    tick(); cpu_read = 1'b0; cpu_write = 1'b0;
    disp_req = 1'b1; disp_addr = 6'd10;
    sample();
    check("rw_no_rdvalid", 32'(cpu_readdatavalid), 0);
    disp_q.push_back(32'hDEAD_BEEF);
    tick(); disp_req = 1'b0;
    sample();

    // Reset mid-read
    tick(); disp_req = 1'b1; disp_addr = 6'd7;
    sample();
    check("rs_dgnt_n", 32'(disp_gnt), 1);
    tick(); reset = 1'b1; cpu_read = 1'b1; cpu_address = 6'd2;
    sample();
    check("rs_rvalid_n1", 32'(disp_rvalid), 0);
    check("rs_dgnt_n1", 32'(disp_gnt), 0);
    check("rs_cpu_wait_n1", 32'(cpu_waitrequest), 1);
    tick();
    sample();
    check("rs_rvalid_n2", 32'(disp_rvalid), 0);
    tick(); reset = 1'b0;
    sample();
    check("rs_after_rvalid", 32'(disp_rvalid), 0);
    check("rs_after_rdvalid", 32'(cpu_readdatavalid), 0);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) sample();
      check($sformatf("rs_wait_%0d", i), 32'(cpu_waitrequest), 1);
      disp_q.push_back(32'hA5A5_0007);
      tick();
    end
    sample();
    check("rs_cpu_win", 32'(cpu_waitrequest), 0);
    cpu_q.push_back(32'hA5A5_0002);
    tick(); cpu_read = 1'b0; disp_req = 1'b0;
    sample();

`ifdef BGIDX_ARB_STATS_EN
    tick(); stat_clear = 1'b1;
    sample();
    tick(); stat_clear = 1'b0;
    sample();
    check("st_clr0_conf", 32'(stat_conflict), 0);
    tick(); disp_req = 1'b1; disp_addr = 6'd3; cpu_read = 1'b1; cpu_address = 6'd4;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 8) cpu_q.push_back(32'hA5A5_0004);
      else        disp_q.push_back(32'hA5A5_0003);
      tick();
    end
    disp_req = 1'b0; cpu_read = 1'b0;
    sample();
    check("st_conflict", 32'(stat_conflict), 10);
    check("st_cpu_gnt", 32'(stat_cpu_gnt), 1);
    check("st_disp_gnt", 32'(stat_disp_gnt), 9);
    tick(); stat_clear = 1'b1;
    tick(); stat_clear = 1'b0;
    sample();
    check("st_clr_conf", 32'(stat_conflict), 0);
    check("st_clr_cpu", 32'(stat_cpu_gnt), 0);
    check("st_clr_disp", 32'(stat_disp_gnt), 0);
`endif

    tick(); tick();
    sample();
    check("disp_q_drained", 32'(disp_q.size()), 0);
    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
